// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, widths,
// the IF/ID slot record and the self-loop (JMP -1) detector.
package if_pkg;

   localparam int INST_W  = 32;
   localparam int IF_PC_W = 32;

   localparam logic [5:0] OP_JMP = 6'b101010;
   localparam logic [5:0] OP_BEZ = 6'b101000;
   localparam logic [5:0] OP_BNE = 6'b101001;

   localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

   // Contents of the IF/ID output slot.
   typedef struct packed {
      logic [IF_PC_W-1:0] pc;
      logic [INST_W-1:0]  inst;
      logic               valid;
   } if_id_t;

   // True for an unconditional jump whose offset is -1, i.e. a jump to itself.
   function automatic logic is_self_loop(input logic [INST_W-1:0] inst);
      return (inst[31:26] == OP_JMP) && (inst[25:0] == {26{1'b1}});
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output slot register. Flush empties the slot (keeps the stale PC),
// load captures a new record, otherwise the slot holds.
module if_id_reg
   import if_pkg::*;
#(
   parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   load_i,
   input  logic   flush_i,
   input  if_id_t data_i,
   output if_id_t slot_o
);

   if_id_t slot_q;
   if_id_t slot_d;

   // Next slot contents: flush wins over load, otherwise hold.
   always_comb begin
      slot_d = slot_q;
      if (flush_i) begin
         slot_d.valid = 1'b0;
         slot_d.inst  = NOP_INST;
      end else if (load_i) begin
         slot_d = data_i;
      end else begin
         slot_d = slot_q;
      end
   end

   // Slot storage with synchronous reset to an empty bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q.pc    <= {IF_PC_W{1'b0}};
         slot_q.inst  <= NOP_INST;
         slot_q.valid <= 1'b0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch front end: owns the PC, addresses the ROM and registers
// {PC+4, instruction} into the IF/ID slot under a valid/ready handshake.
// Optional self-loop halt detection is enabled by defining IF_HALT_DETECT_EN.
module if_stage_fetch
   import if_pkg::*;
#(
   parameter int                PC_W     = 32,
   parameter logic [PC_W-1:0]   RESET_PC = PC_W'(32'h0000_0000),
   parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [PC_W-1:0]   branch_addr,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [PC_W-1:0]   id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic              halted
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] pc_plus4_s;
   logic            halted_q;
   logic            halted_d;
   logic            xfer_s;
   logic            halt_hit_s;
   logic            slot_load_s;
   logic            slot_flush_s;
   if_id_t          slot_in_s;
   if_id_t          slot_s;

   assign imem_addr  = pc_q;
   assign pc_plus4_s = pc_q + PC_W'(32'd4);
   assign xfer_s     = ~slot_s.valid | id_ready;

`ifdef IF_HALT_DETECT_EN
   assign halt_hit_s = is_self_loop(imem_inst);
`else
   assign halt_hit_s = 1'b0;
`endif

   assign slot_in_s.pc    = IF_PC_W'(pc_plus4_s);
   assign slot_in_s.inst  = imem_inst;
   assign slot_in_s.valid = 1'b1;

   // Per-cycle priority: redirect > freeze > halted > transfer > hold.
   always_comb begin
      pc_d         = pc_q;
      halted_d     = halted_q;
      slot_load_s  = 1'b0;
      slot_flush_s = 1'b0;
      if (branch_taken) begin
         pc_d         = {branch_addr[PC_W-1:2], 2'b00};
         halted_d     = 1'b0;
         slot_flush_s = 1'b1;
      end else if (freeze) begin
         pc_d = pc_q;
      end else if (halted_q) begin
         if (xfer_s) begin
            slot_flush_s = 1'b1;
         end else begin
            slot_flush_s = 1'b0;
         end
      end else if (xfer_s) begin
         pc_d        = pc_plus4_s;
         slot_load_s = 1'b1;
         halted_d    = halt_hit_s;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC and halt flag with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (slot_load_s),
      .flush_i (slot_flush_s),
      .data_i  (slot_in_s),
      .slot_o  (slot_s)
   );

   assign id_valid = slot_s.valid;
   assign id_pc    = PC_W'(slot_s.pc);
   assign id_inst  = slot_s.inst;
   assign halted   = halted_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch with a combinational ROM model and
// a behavioural reference of the fetch rules.
module tb_if_stage_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD = 32'hABFF_FFFF;
`ifdef IF_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = 32'h0;
   logic        id_ready = 1'b0;
   logic [31:0] imem_addr, imem_inst, id_pc, id_inst;
   logic        id_valid, halted;

   logic [31:0] rom [0:1023];
   assign imem_inst = rom[imem_addr[11:2]];

   // reference model state
   logic [31:0] m_pc = 32'h0, m_idpc = 32'h0, m_inst = 32'h0;
   bit          m_valid = 1'b0, m_halt = 1'b0;

   int errors = 0;
   int checks = 0;

   if_stage_fetch dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
      .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
      .id_inst(id_inst), .halted(halted)
   );

   always #5 clk = ~clk;

   // advance one clock, updating the reference model from the inputs seen at the edge
   task automatic step();
      logic [31:0] inst;
      bit xfer;
      inst = rom[m_pc[11:2]];
      xfer = !m_valid || id_ready;
      if (rst) begin
         m_pc = 32'h0; m_valid = 0; m_idpc = 32'h0; m_inst = NOP; m_halt = 0;
      end else if (branch_taken) begin
         m_pc = branch_addr & 32'hFFFF_FFFC; m_valid = 0; m_inst = NOP; m_halt = 0;
      end else if (freeze) begin
      end else if (m_halt) begin
         if (xfer) begin m_valid = 0; m_inst = NOP; end
      end else if (xfer) begin
         m_inst = inst; m_idpc = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
         m_halt = HALT_EN && (inst == HALT_WORD);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; freeze = 0; branch_taken = 0; id_ready = 0;
      step(); step();
      rst = 0;
   endtask

   task automatic fill_rom();
      for (int i = 0; i < 1024; i++) begin
         rom[i] = $urandom;
         if (rom[i] == HALT_WORD) rom[i] = 32'h1234_5678;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", id_pc); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", id_inst, NOP); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
   endtask

   task automatic test_stream();
      do_reset();
      id_ready = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (id_pc !== 32'((i + 1) * 4)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, id_pc, (i + 1) * 4); end
         checks++; if (id_inst !== rom[i]) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, id_inst, rom[i]); end
         checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, id_valid); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      id_ready = 1;
      step(); step();
      id_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected 8", i, id_pc); end
         checks++; if (id_inst !== rom[1]) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, id_inst, rom[1]); end
         checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected 8", i, imem_addr); end
         checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, id_valid); end
      end
      id_ready = 1;
      step();
      checks++; if (id_pc !== 32'hC) begin errors++; $display("FAIL bp_release_pc: got %h expected c", id_pc); end
      checks++; if (id_inst !== rom[2]) begin errors++; $display("FAIL bp_release_inst: got %h expected %h", id_inst, rom[2]); end
   endtask

   task automatic test_branch_freeze();
      freeze = 1; branch_taken = 1; branch_addr = 32'h0000_00B9;
      step();
      checks++; if (imem_addr !== 32'hB8) begin errors++; $display("FAIL br_addr: got %h expected b8", imem_addr); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b expected 0", id_valid); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL br_inst: got %h expected %h", id_inst, NOP); end
      freeze = 0; branch_taken = 0; id_ready = 1;
      step();
      checks++; if (id_pc !== 32'hBC) begin errors++; $display("FAIL br_next_pc: got %h expected bc", id_pc); end
      checks++; if (id_inst !== rom[46]) begin errors++; $display("FAIL br_next_inst: got %h expected %h", id_inst, rom[46]); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL br_next_valid: got %b expected 1", id_valid); end
   endtask

   task automatic test_freeze();
      logic [31:0] p, ins, a;
      id_ready = 1;
      p = m_idpc; ins = m_inst; a = m_pc;
      freeze = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (id_pc !== p) begin errors++; $display("FAIL frz_pc[%0d]: got %h expected %h", i, id_pc, p); end
         checks++; if (id_inst !== ins) begin errors++; $display("FAIL frz_inst[%0d]: got %h expected %h", i, id_inst, ins); end
         checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL frz_valid[%0d]: got %b expected 1", i, id_valid); end
         checks++; if (imem_addr !== a) begin errors++; $display("FAIL frz_addr[%0d]: got %h expected %h", i, imem_addr, a); end
      end
      freeze = 0;
   endtask

   task automatic test_wrap();
      branch_taken = 1; branch_addr = 32'hFFFF_FFFE;
      step();
      branch_taken = 0; id_ready = 1;
      step();
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", id_pc); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", imem_addr); end
      checks++; if (id_inst !== rom[1023]) begin errors++; $display("FAIL wrap_inst: got %h expected %h", id_inst, rom[1023]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom % 97) == 0;
         freeze       = ($urandom % 5) == 0;
         branch_taken = ($urandom % 8) == 0;
         branch_addr  = $urandom;
         id_ready     = ($urandom % 3) != 0;
         step();
         checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, imem_addr, m_pc); end
         checks++; if (id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, id_valid, m_valid); end
         checks++; if (id_pc !== m_idpc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, id_pc, m_idpc); end
         checks++; if (id_inst !== m_inst) begin errors++; $display("FAIL rnd_inst[%0d]: got %h expected %h", i, id_inst, m_inst); end
         checks++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted[%0d]: got %b expected %b", i, halted, m_halt); end
      end
      rst = 0; freeze = 0; branch_taken = 0;
   endtask

   task automatic test_halt();
      logic [31:0] save63;
      save63 = rom[63];
      rom[63] = HALT_WORD;
      do_reset();
      id_ready = 1;
      repeat (64) step();
      checks++; if (halted !== HALT_EN) begin errors++; $display("FAIL halt_set: got %b expected %b", halted, HALT_EN); end
      checks++; if (imem_addr !== 32'd256) begin errors++; $display("FAIL halt_addr: got %h expected 100", imem_addr); end
      checks++; if (id_inst !== HALT_WORD) begin errors++; $display("FAIL halt_inst: got %h expected %h", id_inst, HALT_WORD); end
      step();
      checks++; if (id_valid !== !HALT_EN) begin errors++; $display("FAIL halt_drain_valid: got %b expected %b", id_valid, !HALT_EN); end
      checks++; if (id_inst !== (HALT_EN ? NOP : rom[64])) begin errors++; $display("FAIL halt_drain_inst: got %h expected %h", id_inst, HALT_EN ? NOP : rom[64]); end
      step();
      checks++; if (imem_addr !== (HALT_EN ? 32'd256 : 32'd264)) begin errors++; $display("FAIL halt_hold_addr: got %h expected %h", imem_addr, HALT_EN ? 32'd256 : 32'd264); end
      branch_taken = 1; branch_addr = 32'h0;
      step();
      branch_taken = 0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b expected 0", halted); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL halt_redirect_addr: got %h expected 0", imem_addr); end
      step();
      checks++; if (id_inst !== rom[0]) begin errors++; $display("FAIL halt_restart_inst: got %h expected %h", id_inst, rom[0]); end
      checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL halt_restart_pc: got %h expected 4", id_pc); end
      rom[63] = save63;
   endtask

   task automatic test_mid_reset();
      do_reset();
      id_ready = 1;
      repeat (5) step();
      rst = 1;
      step();
      rst = 0;
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mrst_addr: got %h expected 0", imem_addr); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", id_valid); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL mrst_inst: got %h expected %h", id_inst, NOP); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mrst_halted: got %b expected 0", halted); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL mrst_pc: got %h expected 0", id_pc); end
   endtask

   initial begin
      fill_rom();
      test_reset();
      test_stream();
      test_backpressure();
      test_branch_freeze();
      test_freeze();
      test_wrap();
      test_random();
      test_halt();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
